// File: rtl/vga_scanout.sv
// VGA scan-out controller: pixel timing, scaled frame-buffer addressing,
// border handling and colour expansion, with sync/blank aligned to RGB.
module vga_scanout #(
    parameter int ColorBits   = 3,
    parameter int OutBits     = 8,
    parameter int ImageWidth  = 10,
    parameter int ImageHeight = 5,
    parameter int ScaleX      = 64,
    parameter int ScaleY      = 96,
    parameter int XBits       = 9,
    parameter int YBits       = 8,
    parameter int PixelDiv    = 2,
    parameter int HActive     = 640,
    parameter int HFront      = 16,
    parameter int HSync       = 96,
    parameter int HBack       = 48,
    parameter int VActive     = 480,
    parameter int VFront      = 10,
    parameter int VSync       = 2,
    parameter int VBack       = 33
) (
    input  logic                 clk,
    input  logic                 reset,
    output logic [XBits-1:0]     XRead,
    output logic [YBits-1:0]     YRead,
    input  logic [ColorBits-1:0] readValueMemory,
    output logic                 hsync,
    output logic                 vsync,
    output logic                 blank,
    output logic [OutBits-1:0]   red,
    output logic [OutBits-1:0]   green,
    output logic [OutBits-1:0]   blue,
    output logic                 clkVGA,
    output logic                 frameStart
);

    localparam int HTotal = HActive + HFront + HSync + HBack;
    localparam int VTotal = VActive + VFront + VSync + VBack;
    localparam int HW     = $clog2(HTotal + 1);
    localparam int VW     = $clog2(VTotal + 1);
    localparam int DW     = $clog2(PixelDiv);
    localparam int SXW    = $clog2(ScaleX + 1);
    localparam int SYW    = $clog2(ScaleY + 1);
    localparam int FW     = ColorBits / 3;
    localparam int Rep    = (OutBits + FW - 1) / FW;
    localparam int RepW   = Rep * FW;

    localparam logic [DW-1:0]    DivLast = DW'(PixelDiv - 1);
    localparam logic [DW-1:0]    DivHalf = DW'(PixelDiv / 2);
    localparam logic [HW-1:0]    HLast   = HW'(HTotal - 1);
    localparam logic [VW-1:0]    VLast   = VW'(VTotal - 1);
    localparam logic [HW-1:0]    HAct    = HW'(HActive);
    localparam logic [VW-1:0]    VAct    = VW'(VActive);
    localparam logic [HW-1:0]    HSyncS  = HW'(HActive + HFront);
    localparam logic [HW-1:0]    HSyncE  = HW'(HActive + HFront + HSync);
    localparam logic [VW-1:0]    VSyncS  = VW'(VActive + VFront);
    localparam logic [VW-1:0]    VSyncE  = VW'(VActive + VFront + VSync);
    localparam logic [SXW-1:0]   SxLast  = SXW'(ScaleX - 1);
    localparam logic [SYW-1:0]   SyLast  = SYW'(ScaleY - 1);
    localparam logic [XBits-1:0] XLim    = XBits'(ImageWidth);
    localparam logic [XBits-1:0] XMax    = XBits'(ImageWidth - 1);
    localparam logic [YBits-1:0] YLim    = YBits'(ImageHeight);
    localparam logic [YBits-1:0] YMax    = YBits'(ImageHeight - 1);

    logic [DW-1:0]    div;
    logic [DW-1:0]    div_next;
    logic             tick;
    logic [HW-1:0]    h;
    logic [VW-1:0]    v;
    logic [SXW-1:0]   xs;
    logic [SYW-1:0]   ys;
    logic [XBits-1:0] x;
    logic [YBits-1:0] y;
    logic [XBits-1:0] x_sat;
    logic [YBits-1:0] y_sat;
    logic             h_last;
    logic             v_last;
    logic             h_act;
    logic             v_act;
    logic             inside0;
    logic             border0;
    logic             hs0;
    logic             vs0;
    logic             hs1;
    logic             vs1;
    logic             in1;
    logic             bd1;
    logic [RepW-1:0]  rep_r;
    logic [RepW-1:0]  rep_g;
    logic [RepW-1:0]  rep_b;

    // Stage-0 decode: tick, window flags, saturated addresses, colour fan-out
    always_comb begin
        tick     = (div == DivLast);
        div_next = tick ? '0 : div + 1'b1;
        h_last   = (h == HLast);
        v_last   = (v == VLast);
        h_act    = (h < HAct);
        v_act    = (v < VAct);
        inside0  = h_act && v_act;
        border0  = inside0 && ((x >= XLim) || (y >= YLim));
        x_sat    = (x >= XLim) ? XMax : x;
        y_sat    = (y >= YLim) ? YMax : y;
        hs0      = !((h >= HSyncS) && (h < HSyncE));
        vs0      = !((v >= VSyncS) && (v < VSyncE));
        rep_r    = {Rep{readValueMemory[ColorBits-1 -: FW]}};
        rep_g    = {Rep{readValueMemory[ColorBits-FW-1 -: FW]}};
        rep_b    = {Rep{readValueMemory[FW-1:0]}};
    end

    assign frameStart = tick && (h == '0) && (v == '0);

    // Pixel divider and mid-pixel DAC clock
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div    <= '0;
            clkVGA <= 1'b0;
        end else begin
            div    <= div_next;
            clkVGA <= (div_next >= DivHalf);
        end
    end

    // Raster position counters
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            h <= '0;
            v <= '0;
        end else if (tick) begin
            if (h_last) begin
                h <= '0;
                v <= v_last ? '0 : v + 1'b1;
            end else begin
                h <= h + 1'b1;
            end
        end
    end

    // Scaled address sub-counters; counts stop at the image edge
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            x  <= '0;
            xs <= '0;
            y  <= '0;
            ys <= '0;
        end else if (tick) begin
            if (h_last) begin
                x  <= '0;
                xs <= '0;
                if (v_last) begin
                    y  <= '0;
                    ys <= '0;
                end else if (v_act) begin
                    if (ys == SyLast) begin
                        ys <= '0;
                        if (y < YLim) y <= y + 1'b1;
                    end else begin
                        ys <= ys + 1'b1;
                    end
                end
            end else if (h_act) begin
                if (xs == SxLast) begin
                    xs <= '0;
                    if (x < XLim) x <= x + 1'b1;
                end else begin
                    xs <= xs + 1'b1;
                end
            end
        end
    end

    // Stage 1: present the address to memory, carry the flags along
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            XRead <= '0;
            YRead <= '0;
            hs1   <= 1'b1;
            vs1   <= 1'b1;
            in1   <= 1'b0;
            bd1   <= 1'b0;
        end else if (tick) begin
            XRead <= x_sat;
            YRead <= y_sat;
            hs1   <= hs0;
            vs1   <= vs0;
            in1   <= inside0;
            bd1   <= border0;
        end
    end

    // Stage 2: sample memory data, drive all video outputs together
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hsync <= 1'b1;
            vsync <= 1'b1;
            blank <= 1'b0;
            red   <= '0;
            green <= '0;
            blue  <= '0;
        end else if (tick) begin
            hsync <= hs1;
            vsync <= vs1;
            blank <= in1;
            if (in1 && !bd1) begin
                red   <= rep_r[RepW-1 -: OutBits];
                green <= rep_g[RepW-1 -: OutBits];
                blue  <= rep_b[RepW-1 -: OutBits];
            end else begin
                red   <= '0;
                green <= '0;
                blue  <= '0;
            end
        end
    end

endmodule

// File: tb/tb_vga_scanout.sv
// Bench for vga_scanout: reduced geometry, registered memory model,
// per-pixel scoreboard of sync/blank/RGB plus address, clkVGA, frameStart.
module tb_vga_scanout;

    localparam int CB = 6;
    localparam int OB = 4;
    localparam int IW = 3;
    localparam int IH = 2;
    localparam int SX = 4;
    localparam int SY = 3;
    localparam int XB = 4;
    localparam int YB = 3;
    localparam int PD = 4;
    localparam int HA = 16;
    localparam int HF = 2;
    localparam int HS = 3;
    localparam int HB = 3;
    localparam int VA = 8;
    localparam int VF = 1;
    localparam int VS = 2;
    localparam int VB = 2;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int FR = HT * VT;

    typedef struct packed {
        logic          in;
        logic          hs;
        logic          vs;
        logic [OB-1:0] r;
        logic [OB-1:0] g;
        logic [OB-1:0] b;
        logic [XB-1:0] x;
        logic [YB-1:0] y;
    } exp_t;

    logic          clk;
    logic          reset;
    logic [XB-1:0] XRead;
    logic [YB-1:0] YRead;
    logic [CB-1:0] mem_q;
    logic          hsync;
    logic          vsync;
    logic          blank;
    logic [OB-1:0] red;
    logic [OB-1:0] green;
    logic [OB-1:0] blue;
    logic          clkVGA;
    logic          frameStart;

    int   tests;
    int   fails;
    int   n;
    bit   running;
    exp_t q[$];

    vga_scanout #(
        .ColorBits(CB), .OutBits(OB),
        .ImageWidth(IW), .ImageHeight(IH),
        .ScaleX(SX), .ScaleY(SY),
        .XBits(XB), .YBits(YB), .PixelDiv(PD),
        .HActive(HA), .HFront(HF), .HSync(HS), .HBack(HB),
        .VActive(VA), .VFront(VF), .VSync(VS), .VBack(VB)
    ) dut (
        .clk(clk),
        .reset(reset),
        .XRead(XRead),
        .YRead(YRead),
        .readValueMemory(mem_q),
        .hsync(hsync),
        .vsync(vsync),
        .blank(blank),
        .red(red),
        .green(green),
        .blue(blue),
        .clkVGA(clkVGA),
        .frameStart(frameStart)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [CB-1:0] code(input int x, input int y);
        return CB'(x * 5 + y * 11 + 3);
    endfunction

    // one-cycle registered frame-buffer
    always @(posedge clk) mem_q <= code(int'(XRead), int'(YRead));

    always @(posedge clk or posedge reset) begin
        if (reset) n <= 0;
        else       n <= n + 1;
    end

    function automatic exp_t model(input int p);
        exp_t e;
        int h, v, xc, yc, xs, ys;
        logic [CB-1:0] c;
        h  = p % HT;
        v  = (p / HT) % VT;
        xc = ((h < HA) ? h : HA) / SX;
        yc = ((v < VA) ? v : VA) / SY;
        if (xc > IW) xc = IW;
        if (yc > IH) yc = IH;
        xs = (xc >= IW) ? IW - 1 : xc;
        ys = (yc >= IH) ? IH - 1 : yc;
        c  = code(xs, ys);
        e.in = (h < HA) && (v < VA);
        e.hs = !((h >= HA + HF) && (h < HA + HF + HS));
        e.vs = !((v >= VA + VF) && (v < VA + VF + VS));
        e.x  = XB'(xs);
        e.y  = YB'(ys);
        if (e.in && xc < IW && yc < IH) begin
            e.r = {c[5:4], c[5:4]};
            e.g = {c[3:2], c[3:2]};
            e.b = {c[1:0], c[1:0]};
        end else begin
            e.r = '0;
            e.g = '0;
            e.b = '0;
        end
        return e;
    endfunction

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s at n=%0d: got %0h, want %0h",
                     tag, n, got, want);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_x"}, 32'(XRead), 32'd0);
        check({tag, "_y"}, 32'(YRead), 32'd0);
        check({tag, "_hs"}, 32'(hsync), 32'd1);
        check({tag, "_vs"}, 32'(vsync), 32'd1);
        check({tag, "_bl"}, 32'(blank), 32'd0);
        check({tag, "_rgb"}, 32'({red, green, blue}), 32'd0);
        check({tag, "_ck"}, 32'(clkVGA), 32'd0);
        check({tag, "_fs"}, 32'(frameStart), 32'd0);
    endtask

    // Scoreboard: expectation pushed as a position enters stage 0,
    // popped two ticks later when it reaches the outputs.
    always @(negedge clk) begin
        if (running) begin
            exp_t e;
            exp_t a;
            int   k;
            check("clkvga", 32'(clkVGA), 32'((n % PD) >= PD / 2));
            check("fstart", 32'(frameStart),
                  32'(((n + 1) % PD == 0) && ((n / PD) % FR == 0)));
            if (n > 0 && n % PD == 0) begin
                k = n / PD;
                q.push_back(model(k));
                a = model(k - 1);
                if (a.in) begin
                    check("xread", 32'(XRead), 32'(a.x));
                    check("yread", 32'(YRead), 32'(a.y));
                end
                if (q.size() > 2) begin
                    e = q.pop_front();
                    check("hsync", 32'(hsync), 32'(e.hs));
                    check("vsync", 32'(vsync), 32'(e.vs));
                    check("blank", 32'(blank), 32'(e.in));
                    check("red", 32'(red), 32'(e.r));
                    check("green", 32'(green), 32'(e.g));
                    check("blue", 32'(blue), 32'(e.b));
                end
            end
        end
    end

    initial begin
        tests   = 0;
        fails   = 0;
        running = 1'b0;
        reset   = 1'b0;
        #1 reset = 1'b1;
        repeat (3) @(posedge clk);
        #2 check_reset_vals("rst0");
        reset = 1'b0;
        q.delete();
        q.push_back(model(0));
        running = 1'b1;

        repeat (2 * FR * PD + 530) @(posedge clk);
        #2 running = 1'b0;
        reset = 1'b1;
        #1 check_reset_vals("rst_async");
        repeat (3) @(posedge clk);
        #2 check_reset_vals("rst_hold");
        reset = 1'b0;
        q.delete();
        q.push_back(model(0));
        running = 1'b1;

        repeat (FR * PD / 2 + 100) @(posedge clk);
        #2 running = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/vga_scanout.md
# vga_scanout

Parametrised VGA scan-out controller that replaces the fixed-geometry VGA device in the ASIP top level. It generates pixel-rate timing from the system clock and drives `XRead`/`YRead` into the frame-buffer `Memory` read port. It converts the returned `ColorBits` colour code to per-channel DAC values, with sync and blank outputs aligned to the colour data. It adds integer pixel scaling, a border region, configurable porches and a frame-start pulse for the CPU.

## Interface
Parameters:
- `ColorBits`, 3: colour code width; must be a multiple of 3, split equally R|G|B, MSB field = red.
- `OutBits`, 8: DAC width per channel.
- `ImageWidth`, 10; `ImageHeight`, 5: canvas size in memory pixels.
- `ScaleX`, 64; `ScaleY`, 96: screen pixels per memory pixel.
- `XBits`, 9; `YBits`, 8: address widths.
- `PixelDiv`, 2: clk cycles per pixel; even, ≥2.
- `HActive`, 640; `HFront`, 16; `HSync`, 96; `HBack`, 48: horizontal timing in pixels.
- `VActive`, 480; `VFront`, 10; `VSync`, 2; `VBack`, 33: vertical timing in lines.

Ports:
- `clk`, in, 1: system clock.
- `reset`, in, 1: asynchronous, active-high reset.
- `XRead`, out, `XBits`: frame-buffer column address.
- `YRead`, out, `YBits`: frame-buffer row address.
- `readValueMemory`, in, `ColorBits`: colour code at (`XRead`,`YRead`).
- `hsync`, out, 1: horizontal sync, active low.
- `vsync`, out, 1: vertical sync, active low.
- `blank`, out, 1: 1 = active video, 0 = blanking (DAC BLANK_N convention).
- `red`, out, `OutBits`: red DAC value.
- `green`, out, `OutBits`: green DAC value.
- `blue`, out, `OutBits`: blue DAC value.
- `clkVGA`, out, 1: registered pixel clock to the DAC.
- `frameStart`, out, 1: one-clk pulse at the start of each frame.

## Operation
- Divider `div` counts 0..PixelDiv-1. A pixel tick is the clk cycle with `div`==PixelDiv-1.
- `clkVGA` is registered as (next `div` ≥ PixelDiv/2). Its rising edge falls mid-pixel, PixelDiv/2 clks after the outputs change.
- Stage 0, on each tick:
  - `h` counts 0..HTotal-1 (HTotal = sum of the H parameters), then wraps to 0 and increments `v`.
  - `v` counts 0..VTotal-1, then wraps to 0.
- Address generation is sub-counter based, with no dividers:
  - `xs` counts 0..ScaleX-1 during active pixels; on wrap, `XRead` increments.
  - At `h`==HTotal-1, `XRead` and `xs` clear to 0.
  - `YRead` and `ys` behave the same way per line with ScaleY, and clear at end of frame.
- Inside flag: `h`<HActive && `v`<VActive.
- Border: inside, but `XRead` ≥ ImageWidth or `YRead` ≥ ImageHeight. Addresses saturate at ImageWidth-1 / ImageHeight-1 in the border. Border pixels output RGB 0 with `blank`=1.
- `hsync`=0 for `h` in [HActive+HFront, HActive+HFront+HSync). `vsync`=0 for `v` in the equivalent vertical window.
- Stage 1 (next tick): registers `XRead`/`YRead` and delays the sync/inside/border flags.
- Stage 2 (following tick): samples `readValueMemory`.
  - Each field of ColorBits/3 bits is replicated to fill `OutBits` (1-bit field 1 → 8'hFF).
  - When not inside, or in the border, RGB = 0.
- `hsync`, `vsync` and `blank` are delayed to stage 2, so all video outputs change on the same clk edge.
- `frameStart`: a one-clk pulse in the tick cycle where stage 0 is at `h`=0, `v`=0.

## Timing
- Reset values: all counters 0; `XRead`=0, `YRead`=0; `hsync`=1, `vsync`=1; `blank`=0; `red`/`green`/`blue`=0; `clkVGA`=0; `frameStart`=0; pipeline flags cleared to "not inside, no sync".
- Reset asserted mid-frame returns all outputs to reset values immediately, without waiting for a clock.
- After reset deassertion:
  - The first tick occurs on the PixelDiv-th rising clk edge.
  - The first `frameStart` occurs in the first tick cycle.
  - The first valid colour appears on the outputs 2 ticks after stage 0 reaches (0,0).
- Memory read latency must be < PixelDiv clks. `readValueMemory` is sampled PixelDiv clks after the `XRead`/`YRead` update, so both combinational and 1-cycle registered memories are supported.
- Line = HTotal ticks; frame = HTotal·VTotal ticks = HTotal·VTotal·PixelDiv clks.
- Output sync pulses are exactly HSync ticks (horizontal) and VSync·HTotal ticks (vertical) long.

## Test plan
- Default parameters: reset asserted at clk 1000 mid-line, deasserted at clk 1005 → all outputs at reset values during reset; `frameStart` then repeats every 840000 clks.
- Default parameters: measure one line → 800 ticks per line; `hsync` low for 96 ticks starting 656 ticks after `blank` rises; `blank`=1 for 640 ticks.
- Model memory returning {X[0],Y[0],1} with 1-cycle registered latency:
  - At stage-0 `h`=63 → `XRead`=0; at `h`=64 → `XRead`=1.
  - Line `v`=96 → `YRead`=1.
  - Output colour changes exactly at screen column 64.
- Constant memory code 3'b101 → inside: red=8'hFF, green=0, blue=8'hFF; during blanking: RGB=0 and `blank`=0.
- Reduced config (`ColorBits`=6, `OutBits`=4, `ImageWidth`=3, `ScaleX`=4, `HActive`=16, small porches), memory code 6'b11_01_10 → red=4'hF, green=4'h5, blue=4'hA for columns 0..11; columns 12..15 are border with RGB=0 and `blank`=1; `XRead` saturates at 2.
- `clkVGA` check, `PixelDiv`=4 → `clkVGA` has period 4 clks and 50% duty; its rising edge is 2 clks after each RGB update.
